spi_target_regs: RTL and testbench
==================================

# spi_target_regs

Three-wire SPI target (responder) that lets an external SPI controller read and write a register bank inside the DAQ firmware. It oversamples `sclk`, `csb` and `sdio` in the local `clk` domain, decodes a 16-bit command/data frame, and issues single-cycle register read/write strobes to a register file. During read frames it turns `sdio` around and drives the data back to the controller.

## Interface
- `ADDR_W`, 7: register address width.
- `DATA_W`, 8: register data width; frame length is 1 + `ADDR_W` + `DATA_W` bits.
- `clk` input 1: local clock; must run at ≥16× `sclk` frequency.
- `reset` input 1: reset, asynchronous, active-high.
- `sclk` input 1: SPI clock from controller; idles high.
- `csb` input 1: chip select, active-low.
- `sdio` inout 1: bidirectional serial data; driven only while `sdio_oe`=1, otherwise high-Z.
- `reg_addr` output `ADDR_W`: register address, valid with `reg_we`/`reg_re`.
- `reg_wdata` output `DATA_W`: write data, valid with `reg_we`.
- `reg_we` output 1: one-`clk` write strobe.
- `reg_re` output 1: one-`clk` read strobe.
- `reg_rdata` input `DATA_W`: read data, sampled exactly 1 `clk` after `reg_re`.
- `sdio_oe` output 1: target is driving `sdio`.
- `frame_err` output 1: one-`clk` pulse when a frame is aborted.

## Operation
- Inputs `sclk`, `csb`, `sdio` pass through 2-FF synchronizers. Edge detectors on synchronized `sclk` produce `rise`/`fall` pulses.
- Bit order MSB first. Frame: bit 0 = R/W (1 = read), next `ADDR_W` bits = address, last `DATA_W` bits = data.
- Controller launches on `sclk` fall; target samples `sdio` on `rise`. During read data, target launches on `fall` and controller samples on rise.
- States:
  - IDLE: wait for synchronized `csb`=0 → CMD, bit counter cleared.
  - CMD: shift 1+`ADDR_W` bits on `rise`. After the last bit:
    - If write → WDATA.
    - If read → pulse `reg_re` with the address, capture `reg_rdata` next `clk` into the output shifter → RDATA.
  - WDATA: shift `DATA_W` bits. On the last `rise`, pulse `reg_we` 1 `clk` later with `reg_addr`/`reg_wdata` → DONE.
  - RDATA: on each `fall`, drive the shifter MSB onto `sdio` with `sdio_oe`=1, then shift left. After `DATA_W` bits have been launched, the next `fall` clears `sdio_oe` → DONE.
  - DONE: ignore `sclk` until `csb`=1 → IDLE.
- Abort: synchronized `csb` rising in CMD, WDATA or RDATA → IDLE, `sdio_oe`=0, one `frame_err` pulse, no `reg_we`. A `reg_re` already issued is not retracted.
- `reg_we` and `reg_re` are never asserted in the same cycle.

## Timing
- Reset values:
  - `reg_addr`=0, `reg_wdata`=0, `reg_we`=0, `reg_re`=0, `sdio_oe`=0, `frame_err`=0.
  - State IDLE, all shifters 0.
- Input-to-edge latency is 3 `clk` (2 sync + 1 detect).
- `reg_re` is asserted 1 `clk` after the `rise` for the final address bit. Read data is registered 2 `clk` after that `rise`, ahead of the following `fall` because `clk` ≥16× `sclk`.
- `reg_we` is asserted 1 `clk` after the `rise` for the final data bit. `reg_addr`/`reg_wdata` hold their values until the next strobe.
- `sdio_oe` goes high at the first `fall` after CMD completes and low at the `fall` following the last data bit. It also drops within 1 `clk` of a detected `csb` deassertion.
- Back-to-back frames require only `csb` high for ≥4 `clk`.
- `reset` mid-frame: all outputs return to reset values immediately and `sdio` is released.

## Configuration
- `SPI_TARGET_BURST_EN` defined:
  - After a completed data word with `csb` still low, the address auto-increments (wrapping at 2^`ADDR_W`).
  - The next `DATA_W` bits form another word in the same direction, with a new `reg_we`, or a new `reg_re` issued at the word boundary.
  - DONE is entered only on `csb`=1.
  - A partial burst word dropped by `csb` does not assert `frame_err` if ≥1 word completed.
- Undefined: after one word, state is DONE and extra `sclk` edges are ignored.

## Test plan
- Write frame 0x053C (W, addr 0x05, data 0x3C) → single `reg_we` with `reg_addr`=0x05, `reg_wdata`=0x3C; `sdio_oe` stays 0.
- Read frame to addr 0x12 with `reg_rdata`=0xA5 → one `reg_re` with addr 0x12; `sdio` carries 1,0,1,0,0,1,0,1 on successive rises; `sdio_oe` low after the last bit.
- `csb` raised after 11 bits of a write → `frame_err` pulse, no `reg_we`, state IDLE; the next full frame completes normally.
- `reset` asserted mid-read while `sdio_oe`=1 → `sdio_oe`=0 immediately; all strobes 0.
- 24 `sclk` cycles, write addr 0x7F, data 0x11 then 0x22:
  - With `SPI_TARGET_BURST_EN`: `reg_we` to 0x7F/0x11, then to 0x00/0x22.
  - Without it: only the 0x7F/0x11 write.
- Two back-to-back writes with `csb` high 4 `clk` between them → both `reg_we` pulses are observed.

Source files
------------

// File: rtl/spi_target_regs_if.sv
// Register-bus interface between spi_target_regs (master) and the register file (slave).
// reg_rdata is returned by the slave one clk after reg_re.
interface spi_target_regs_if #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 8
);
   logic [ADDR_W-1:0] reg_addr;
   logic [DATA_W-1:0] reg_wdata;
   logic              reg_we;
   logic              reg_re;
   logic [DATA_W-1:0] reg_rdata;

   modport master (output reg_addr, output reg_wdata, output reg_we, output reg_re,
                   input reg_rdata);
   modport slave  (input reg_addr, input reg_wdata, input reg_we, input reg_re,
                   output reg_rdata);
endinterface

// File: rtl/spi_target_regs.sv
// Three-wire SPI target bridging an external controller onto a register bus.
// Optional macro SPI_TARGET_BURST_EN enables address auto-increment bursts.
module spi_target_regs #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sclk,
   input  logic              csb,
   inout  wire               sdio,
   output logic              sdio_oe,
   output logic              frame_err,
   spi_target_regs_if.master regs
);

`ifdef SPI_TARGET_BURST_EN
   localparam bit BURST_EN = 1'b1;
`else
   localparam bit BURST_EN = 1'b0;
`endif

   localparam int CMD_W   = 1 + ADDR_W;
   localparam int SHIFT_W = (CMD_W > DATA_W) ? CMD_W : DATA_W;
   localparam int CNT_W   = $clog2(SHIFT_W + 1);
   localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_W - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] DATA_FULL = CNT_W'(DATA_W);

   typedef enum logic [2:0] {S_IDLE, S_CMD, S_WDATA, S_RDATA, S_DONE} state_t;

   // Synchronizers: index 2 = sclk, 1 = csb, 0 = sdio; sclk/csb reset to their idle-high level
   localparam logic [2:0] SYNC_INIT = 3'b110;
   logic [2:0] raw_in;
   logic [2:0] sync_out;
   assign raw_in = {sclk, csb, sdio};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_sync
         logic [1:0] sync_reg;
         always_ff @(posedge clk or posedge reset) begin
            if (reset) sync_reg <= {2{SYNC_INIT[gi]}};
            else       sync_reg <= {sync_reg[0], raw_in[gi]};
         end
         assign sync_out[gi] = sync_reg[1];
      end
   endgenerate

   logic sclk_s, csb_s, sdio_s, sclk_prev_reg, sclk_rise, sclk_fall;
   assign sclk_s    = sync_out[2];
   assign csb_s     = sync_out[1];
   assign sdio_s    = sync_out[0];
   assign sclk_rise = sclk_s & ~sclk_prev_reg;
   assign sclk_fall = ~sclk_s & sclk_prev_reg;

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   bit_cnt_reg, bit_cnt_next;
   logic [SHIFT_W-1:0] rx_shift_reg, rx_shift_next, rx_shifted;
   logic [DATA_W-1:0]  tx_shift_reg, tx_shift_next;
   logic [ADDR_W-1:0]  word_addr_reg, word_addr_next;
   logic               word_done_reg, word_done_next;
   logic [ADDR_W-1:0]  reg_addr_reg, reg_addr_next;
   logic [DATA_W-1:0]  reg_wdata_reg, reg_wdata_next;
   logic               reg_we_reg, reg_we_next;
   logic               reg_re_reg, reg_re_next;
   logic               cap_pending_reg;
   logic               sdio_out_reg, sdio_out_next;
   logic               sdio_oe_reg, sdio_oe_next;
   logic               frame_err_reg, frame_err_next;
   logic               in_frame;

   assign in_frame = (state_reg == S_CMD) || (state_reg == S_WDATA) || (state_reg == S_RDATA);

   always_comb begin
      state_next     = state_reg;
      bit_cnt_next   = bit_cnt_reg;
      rx_shift_next  = rx_shift_reg;
      tx_shift_next  = tx_shift_reg;
      word_addr_next = word_addr_reg;
      word_done_next = word_done_reg;
      reg_addr_next  = reg_addr_reg;
      reg_wdata_next = reg_wdata_reg;
      reg_we_next    = 1'b0;
      reg_re_next    = 1'b0;
      sdio_out_next  = sdio_out_reg;
      sdio_oe_next   = sdio_oe_reg;
      frame_err_next = 1'b0;
      rx_shifted     = {rx_shift_reg[SHIFT_W-2:0], sdio_s};

      // Read data arrives one clk after the reg_re pulse
      if (cap_pending_reg) tx_shift_next = regs.reg_rdata;

      if (in_frame && csb_s) begin
         // A burst that already finished a word ends cleanly on csb release
         state_next     = S_IDLE;
         sdio_oe_next   = 1'b0;
         frame_err_next = ~word_done_reg;
      end else begin
         case (state_reg)
            S_IDLE: begin
               sdio_oe_next = 1'b0;
               if (!csb_s) begin
                  state_next     = S_CMD;
                  bit_cnt_next   = '0;
                  rx_shift_next  = '0;
                  word_done_next = 1'b0;
               end
            end
            S_CMD: begin
               if (sclk_rise) begin
                  rx_shift_next = rx_shifted;
                  bit_cnt_next  = bit_cnt_reg + CNT_W'(1);
                  if (bit_cnt_reg == CMD_LAST) begin
                     bit_cnt_next   = '0;
                     word_addr_next = rx_shifted[ADDR_W-1:0];
                     if (rx_shifted[ADDR_W]) begin
                        reg_re_next   = 1'b1;
                        reg_addr_next = rx_shifted[ADDR_W-1:0];
                        state_next    = S_RDATA;
                     end else begin
                        state_next = S_WDATA;
                     end
                  end
               end
            end
            S_WDATA: begin
               if (sclk_rise) begin
                  rx_shift_next = rx_shifted;
                  bit_cnt_next  = bit_cnt_reg + CNT_W'(1);
                  if (bit_cnt_reg == DATA_LAST) begin
                     bit_cnt_next   = '0;
                     reg_we_next    = 1'b1;
                     reg_addr_next  = word_addr_reg;
                     reg_wdata_next = rx_shifted[DATA_W-1:0];
                     if (BURST_EN) begin
                        word_done_next = 1'b1;
                        word_addr_next = word_addr_reg + ADDR_W'(1);
                     end else begin
                        state_next = S_DONE;
                     end
                  end
               end
            end
            S_RDATA: begin
               if (sclk_fall) begin
                  if (bit_cnt_reg != DATA_FULL) begin
                     sdio_out_next = tx_shift_reg[DATA_W-1];
                     sdio_oe_next  = 1'b1;
                     tx_shift_next = {tx_shift_reg[DATA_W-2:0], 1'b0};
                     bit_cnt_next  = bit_cnt_reg + CNT_W'(1);
                  end else begin
                     sdio_oe_next = 1'b0;
                     state_next   = S_DONE;
                  end
               end else if (sclk_rise && bit_cnt_reg == DATA_FULL) begin
                  // Controller has sampled the last bit of this word
                  word_done_next = 1'b1;
                  if (BURST_EN) begin
                     bit_cnt_next   = '0;
                     word_addr_next = word_addr_reg + ADDR_W'(1);
                     reg_addr_next  = word_addr_reg + ADDR_W'(1);
                     reg_re_next    = 1'b1;
                  end
               end
            end
            S_DONE: begin
               if (csb_s) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg       <= S_IDLE;
         bit_cnt_reg     <= '0;
         rx_shift_reg    <= '0;
         tx_shift_reg    <= '0;
         word_addr_reg   <= '0;
         word_done_reg   <= 1'b0;
         reg_addr_reg    <= '0;
         reg_wdata_reg   <= '0;
         reg_we_reg      <= 1'b0;
         reg_re_reg      <= 1'b0;
         cap_pending_reg <= 1'b0;
         sdio_out_reg    <= 1'b0;
         sdio_oe_reg     <= 1'b0;
         frame_err_reg   <= 1'b0;
         sclk_prev_reg   <= 1'b1;
      end else begin
         state_reg       <= state_next;
         bit_cnt_reg     <= bit_cnt_next;
         rx_shift_reg    <= rx_shift_next;
         tx_shift_reg    <= tx_shift_next;
         word_addr_reg   <= word_addr_next;
         word_done_reg   <= word_done_next;
         reg_addr_reg    <= reg_addr_next;
         reg_wdata_reg   <= reg_wdata_next;
         reg_we_reg      <= reg_we_next;
         reg_re_reg      <= reg_re_next;
         cap_pending_reg <= reg_re_reg;
         sdio_out_reg    <= sdio_out_next;
         sdio_oe_reg     <= sdio_oe_next;
         frame_err_reg   <= frame_err_next;
         sclk_prev_reg   <= sclk_s;
      end
   end

   assign regs.reg_addr  = reg_addr_reg;
   assign regs.reg_wdata = reg_wdata_reg;
   assign regs.reg_we    = reg_we_reg;
   assign regs.reg_re    = reg_re_reg;
   assign sdio_oe        = sdio_oe_reg;
   assign frame_err      = frame_err_reg;
   assign sdio           = sdio_oe_reg ? sdio_out_reg : 1'bz;

endmodule

// File: tb/tb_spi_target_regs.sv
// Scoreboard bench for spi_target_regs: directed SPI frames push expected bus events,
// a monitor compares every reg_we / reg_re / frame_err pulse against the queue.
module tb_spi_target_regs;
   localparam int ADDR_W = 7;
   localparam int DATA_W = 8;
   localparam int HALF   = 10;   // sclk half period in clk cycles

   localparam logic [1:0] K_WE  = 2'd0;
   localparam logic [1:0] K_RE  = 2'd1;
   localparam logic [1:0] K_ERR = 2'd2;

   typedef struct packed {
      logic [1:0]        kind;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } ev_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic sclk = 1'b1;
   logic csb = 1'b1;
   logic tb_sdio_en = 1'b0;
   logic tb_sdio_val = 1'b0;
   wire  sdio;
   logic sdio_oe;
   logic frame_err;

   int vectors = 0;
   int miscompares = 0;
   ev_t exp_q[$];
   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   assign sdio = tb_sdio_en ? tb_sdio_val : 1'bz;

   spi_target_regs_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) regs_bus ();

   spi_target_regs #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .sclk      (sclk),
      .csb       (csb),
      .sdio      (sdio),
      .sdio_oe   (sdio_oe),
      .frame_err (frame_err),
      .regs      (regs_bus)
   );

   always #5 clk = ~clk;

   // Register file: read data returned one clk after reg_re
   always @(posedge clk) begin
      if (regs_bus.reg_re) regs_bus.reg_rdata <= mem[regs_bus.reg_addr];
   end

   function automatic void push(input logic [1:0] kind, input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] data);
      ev_t e;
      e.kind = kind;
      e.addr = addr;
      e.data = data;
      exp_q.push_back(e);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end else begin
         $display("ok   %s = %h", name, act);
      end
   endtask

   // Monitor / scoreboard
   initial begin
      ev_t got;
      ev_t want;
      forever begin
         @(negedge clk);
         if (!reset && (regs_bus.reg_we || regs_bus.reg_re || frame_err)) begin
            got.kind = regs_bus.reg_we ? K_WE : (regs_bus.reg_re ? K_RE : K_ERR);
            got.addr = (got.kind == K_ERR) ? '0 : regs_bus.reg_addr;
            got.data = (got.kind == K_WE) ? regs_bus.reg_wdata : '0;
            vectors++;
            if (regs_bus.reg_we && regs_bus.reg_re) begin
               miscompares++;
               $display("FAIL strobe_overlap actual we=1 re=1 required at most one");
            end else if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_event actual kind=%0d addr=%h data=%h required none",
                        got.kind, got.addr, got.data);
            end else begin
               want = exp_q.pop_front();
               if (got !== want) begin
                  miscompares++;
                  $display("FAIL bus_event actual kind=%0d addr=%h data=%h required kind=%0d addr=%h data=%h",
                           got.kind, got.addr, got.data, want.kind, want.addr, want.data);
               end else begin
                  $display("ok   bus_event kind=%0d addr=%h data=%h", got.kind, got.addr, got.data);
               end
            end
         end
      end
   end

   // One SPI frame; the first drv_bits bits are driven by the controller, the rest sampled
   task automatic spi_frame(input int nbits, input logic [31:0] bits, input int drv_bits,
                            input int gap, output logic [31:0] rx);
      rx = '0;
      csb = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         sclk = 1'b0;
         if (i < drv_bits) begin
            tb_sdio_en  = 1'b1;
            tb_sdio_val = bits[nbits-1-i];
         end else begin
            tb_sdio_en = 1'b0;
         end
         repeat (HALF) @(negedge clk);
         sclk = 1'b1;
         rx = {rx[30:0], sdio};
         repeat (HALF) @(negedge clk);
      end
      tb_sdio_en = 1'b0;
      csb = 1'b1;
      repeat (gap) @(negedge clk);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] rx;
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'(i ^ 8'h5A);
      mem[7'h12] = 8'hA5;
      mem[7'h33] = 8'h96;

      repeat (3) @(negedge clk);
      check("rst_reg_addr",  32'(regs_bus.reg_addr),  32'h0);
      check("rst_reg_wdata", 32'(regs_bus.reg_wdata), 32'h0);
      check("rst_reg_we",    32'(regs_bus.reg_we),    32'h0);
      check("rst_reg_re",    32'(regs_bus.reg_re),    32'h0);
      check("rst_sdio_oe",   32'(sdio_oe),            32'h0);
      check("rst_frame_err", 32'(frame_err),          32'h0);
      reset = 1'b0;
      repeat (4) @(negedge clk);

      // Write 0x3C to 0x05
      push(K_WE, 7'h05, 8'h3C);
      spi_frame(16, 32'h053C, 16, 8, rx);
      check("write_oe_low", 32'(sdio_oe), 32'h0);

      // Read 0x12, register returns 0xA5
      push(K_RE, 7'h12, 8'h00);
      spi_frame(16, 32'h9200, 8, 8, rx);
      check("read_data_bits", 32'(rx[7:0]), 32'hA5);
      check("read_oe_after",  32'(sdio_oe), 32'h0);

      // Write aborted after 11 bits, then a normal write
      push(K_ERR, 7'h00, 8'h00);
      spi_frame(11, 32'h053C >> 5, 11, 8, rx);
      check("abort_oe_low", 32'(sdio_oe), 32'h0);
      push(K_WE, 7'h2A, 8'h5A);
      spi_frame(16, 32'h2A5A, 16, 8, rx);

      // 24-bit write starting at 0x7F
      push(K_WE, 7'h7F, 8'h11);
`ifdef SPI_TARGET_BURST_EN
      push(K_WE, 7'h00, 8'h22);
`endif
      spi_frame(24, 32'h7F1122, 24, 8, rx);

      // Back-to-back writes with csb high for 4 clk
      push(K_WE, 7'h01, 8'hC3);
      push(K_WE, 7'h40, 8'h7E);
      spi_frame(16, 32'h01C3, 16, 4, rx);
      spi_frame(16, 32'h407E, 16, 8, rx);
      check("b2b_last_addr",  32'(regs_bus.reg_addr),  32'h40);
      check("b2b_last_wdata", 32'(regs_bus.reg_wdata), 32'h7E);

      // Reset in the middle of a read from 0x33 while sdio is driven
      push(K_RE, 7'h33, 8'h00);
      csb = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         sclk = 1'b0;
         if (i < 8) begin
            tb_sdio_en  = 1'b1;
            tb_sdio_val = 1'(8'hB3 >> (7 - i));
         end else begin
            tb_sdio_en = 1'b0;
         end
         repeat (HALF) @(negedge clk);
         sclk = 1'b1;
         repeat (HALF) @(negedge clk);
      end
      sclk = 1'b0;
      repeat (4) @(negedge clk);
      check("midread_oe_high", 32'(sdio_oe), 32'h1);
      #1 reset = 1'b1;
      #1;
      check("midread_rst_oe",   32'(sdio_oe),           32'h0);
      check("midread_rst_we",   32'(regs_bus.reg_we),   32'h0);
      check("midread_rst_re",   32'(regs_bus.reg_re),   32'h0);
      check("midread_rst_addr", 32'(regs_bus.reg_addr), 32'h0);
      check("midread_rst_err",  32'(frame_err),         32'h0);
      sclk = 1'b1;
      csb  = 1'b1;
      tb_sdio_en = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);

      // Controller recovers after reset
      push(K_WE, 7'h66, 8'h99);
      spi_frame(16, 32'h6699, 16, 20, rx);

      check("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
